ssram_arbiter: RTL and testbench

- Shares one 32-bit byte-laned synchronous SRAM bank (four 8-bit sync_ram_wf lanes) between two requesters.
  - Port A: AHB-side ahb_to_ssram path.
  - Port B: secondary master, e.g. a DMA or debug loader.
- Arbitration is round-robin with a bounded burst hold, so either port can stream consecutive accesses without starving the other.
- Sits between the requesters and the RAM lanes in chip-level integrations and drives the lane enable, write-strobe, address and data buses.

---
 rtl/ssram_arbiter_if.sv | 50 +++++
 rtl/ssram_arbiter.sv | 101 ++++++++++
 tb/tb_ssram_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssram_arbiter_if.sv
// rtl/ssram_arbiter_if.sv - requester and RAM-lane bundle for ssram_arbiter
//
// Port A / port B: req, addr (byte address), we (byte strobes, 0 = read),
//   wdata in; gnt (combinational), rvalid (registered), rdata out.
// RAM side: sram_addr (word address), sram_enb, sram_wb, sram_din out;
//   sram_dout in (valid one cycle after the enable).
// slave  = arbiter view, master = requester/RAM view.
interface ssram_arbiter_if #(
    parameter int AW = 12
) ();
    logic          req_a;
    logic [AW-1:0] addr_a;
    logic [3:0]    we_a;
    logic [31:0]   wdata_a;
    logic          gnt_a;
    logic          rvalid_a;
    logic [31:0]   rdata_a;

    logic          req_b;
    logic [AW-1:0] addr_b;
    logic [3:0]    we_b;
    logic [31:0]   wdata_b;
    logic          gnt_b;
    logic          rvalid_b;
    logic [31:0]   rdata_b;

    logic [AW-3:0] sram_addr;
    logic [3:0]    sram_enb;
    logic [3:0]    sram_wb;
    logic [31:0]   sram_din;
    logic [31:0]   sram_dout;

    modport slave (
        input  req_a, addr_a, we_a, wdata_a,
        output gnt_a, rvalid_a, rdata_a,
        input  req_b, addr_b, we_b, wdata_b,
        output gnt_b, rvalid_b, rdata_b,
        output sram_addr, sram_enb, sram_wb, sram_din,
        input  sram_dout
    );

    modport master (
        output req_a, addr_a, we_a, wdata_a,
        input  gnt_a, rvalid_a, rdata_a,
        output req_b, addr_b, we_b, wdata_b,
        input  gnt_b, rvalid_b, rdata_b,
        input  sram_addr, sram_enb, sram_wb, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/ssram_arbiter.sv
// rtl/ssram_arbiter.sv - round-robin two-port arbiter for a 32-bit byte-laned sync SRAM
//
// Ports:
//   HCLK     clock, rising edge
//   HRESETn  asynchronous active-low reset
//   bus      ssram_arbiter_if.slave: two requester ports plus RAM-lane drive
// Parameters:
//   AW        byte address width (RAM word address = addr[AW-1:2])
//   MAX_BURST consecutive grants to one owner while the other port waits (1..15)
module ssram_arbiter #(
    parameter int AW        = 12,
    parameter int MAX_BURST = 4
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ssram_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t     state, state_nx;
    logic       last_b, last_b_nx;   // 1: port B was granted most recently
    logic [3:0] cnt, cnt_nx;
    logic       grant_a, grant_b;
    logic       rvalid_a_q, rvalid_b_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            last_b     <= 1'b1;      // A wins the first tie after reset
            cnt        <= 4'd0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            state      <= state_nx;
            last_b     <= last_b_nx;
            cnt        <= cnt_nx;
            rvalid_a_q <= grant_a && (bus.we_a == 4'b0000);
            rvalid_b_q <= grant_b && (bus.we_b == 4'b0000);
        end
    end

    // Owner keeps the bank until it drops its request or uses up its burst
    // while the other port is waiting; the yield happens in the same cycle,
    // so an owner switch costs no bubble.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            OWN_A: begin
                if (bus.req_a && (cnt < MAX_CNT || !bus.req_b)) grant_a = 1'b1;
                else if (bus.req_b)                             grant_b = 1'b1;
            end
            OWN_B: begin
                if (bus.req_b && (cnt < MAX_CNT || !bus.req_a)) grant_b = 1'b1;
                else if (bus.req_a)                             grant_a = 1'b1;
            end
            default: begin
                if (bus.req_a && bus.req_b) begin
                    grant_a = last_b;
                    grant_b = !last_b;
                end else begin
                    grant_a = bus.req_a;
                    grant_b = bus.req_b;
                end
            end
        endcase
    end

    // cnt saturates at MAX_BURST so a lone requester never wraps it.
    always_comb begin
        state_nx  = IDLE;
        cnt_nx    = 4'd0;
        last_b_nx = last_b;
        if (grant_a) begin
            state_nx  = OWN_A;
            last_b_nx = 1'b0;
            if (state == OWN_A) cnt_nx = (cnt >= MAX_CNT) ? cnt : cnt + 4'd1;
            else                cnt_nx = 4'd1;
        end else if (grant_b) begin
            state_nx  = OWN_B;
            last_b_nx = 1'b1;
            if (state == OWN_B) cnt_nx = (cnt >= MAX_CNT) ? cnt : cnt + 4'd1;
            else                cnt_nx = 4'd1;
        end
    end

    assign bus.gnt_a    = grant_a;
    assign bus.gnt_b    = grant_b;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.rdata_a  = bus.sram_dout;
    assign bus.rdata_b  = bus.sram_dout;

    // Address/data default to port A when idle; only enb/wb qualify the cycle.
    assign bus.sram_enb  = {4{grant_a | grant_b}};
    assign bus.sram_wb   = grant_b ? bus.we_b : (grant_a ? bus.we_a : 4'b0000);
    assign bus.sram_addr = grant_b ? bus.addr_b[AW-1:2] : bus.addr_a[AW-1:2];
    assign bus.sram_din  = grant_b ? bus.wdata_b : bus.wdata_a;
endmodule

// File: tb/tb_ssram_arbiter.sv
// tb/tb_ssram_arbiter.sv - self-checking bench for ssram_arbiter
module tb_ssram_arbiter;
    localparam int AW = 12;
    localparam int MB = 4;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ssram_arbiter_if #(.AW(AW)) bus0 ();
    ssram_arbiter_if #(.AW(AW)) bus1 ();

    ssram_arbiter #(.AW(AW), .MAX_BURST(MB)) u0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0.slave));
    ssram_arbiter #(.AW(AW), .MAX_BURST(1))  u1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (we[l]) r[l*8 +: 8] = din[l*8 +: 8];
        return r;
    endfunction

    // RAM lanes behind u0: write-first, one-cycle read latency
    logic [31:0] sram [0:1023];
    logic [31:0] dout_q;
    initial for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
    always @(posedge HCLK) begin
        if (bus0.sram_enb == 4'b1111) begin
            sram[bus0.sram_addr] <= merge(sram[bus0.sram_addr], bus0.sram_din, bus0.sram_wb);
            dout_q               <= merge(sram[bus0.sram_addr], bus0.sram_din, bus0.sram_wb);
        end
    end
    assign bus0.sram_dout = dout_q;
    assign bus1.sram_dout = 32'h0;

    // Scoreboard: read transfers push expected data; the rvalid cycle pops it.
    logic [31:0] ref_mem [0:1023];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic pend_a = 1'b0, pend_b = 1'b0;
    initial for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

    initial forever begin
        @(negedge HCLK);
        if (!HRESETn) begin
            pend_a = 1'b0; pend_b = 1'b0;
            qa.delete(); qb.delete();
            chk("rst_rvalid_a", 32'(bus0.rvalid_a), 32'd0);
            chk("rst_rvalid_b", 32'(bus0.rvalid_b), 32'd0);
        end else begin
            chk("rvalid_a", 32'(bus0.rvalid_a), 32'(pend_a));
            chk("rvalid_b", 32'(bus0.rvalid_b), 32'(pend_b));
            if (bus0.rvalid_a && qa.size() > 0) chk("rdata_a", bus0.rdata_a, qa.pop_front());
            if (bus0.rvalid_b && qb.size() > 0) chk("rdata_b", bus0.rdata_b, qb.pop_front());
            pend_a = bus0.req_a && bus0.gnt_a && (bus0.we_a == 4'b0000);
            pend_b = bus0.req_b && bus0.gnt_b && (bus0.we_b == 4'b0000);
            if (pend_a) qa.push_back(ref_mem[bus0.addr_a[AW-1:2]]);
            if (pend_b) qb.push_back(ref_mem[bus0.addr_b[AW-1:2]]);
            if (bus0.req_a && bus0.gnt_a && bus0.we_a != 4'b0000)
                ref_mem[bus0.addr_a[AW-1:2]] = merge(ref_mem[bus0.addr_a[AW-1:2]], bus0.wdata_a, bus0.we_a);
            if (bus0.req_b && bus0.gnt_b && bus0.we_b != 4'b0000)
                ref_mem[bus0.addr_b[AW-1:2]] = merge(ref_mem[bus0.addr_b[AW-1:2]], bus0.wdata_b, bus0.we_b);
        end
    end

    typedef struct {
        logic        ra, rb;
        logic [3:0]  wa, wb;
        logic [11:0] aa, ab;
        logic [31:0] da, db;
        logic        ga, gb;
        logic [3:0]  ewb;
        logic [9:0]  eaddr;
        logic [31:0] edin;
    } vec_t;
    vec_t vecs [11];

    task automatic drv(input logic ra, input logic rb, input logic [3:0] wa, input logic [3:0] wb,
                       input logic [11:0] aa, input logic [11:0] ab,
                       input logic [31:0] da, input logic [31:0] db);
        bus0.req_a = ra; bus0.we_a = wa; bus0.addr_a = aa; bus0.wdata_a = da;
        bus0.req_b = rb; bus0.we_b = wb; bus0.addr_b = ab; bus0.wdata_b = db;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 4'h0, 12'h010, 12'h000, 32'h11223344, 32'h0, 1'b1, 1'b0, 4'hF, 10'h004, 32'h11223344};
        vecs[1]  = '{1'b1, 1'b0, 4'hF, 4'h0, 12'h014, 12'h000, 32'h55667788, 32'h0, 1'b1, 1'b0, 4'hF, 10'h005, 32'h55667788};
        vecs[2]  = '{1'b1, 1'b0, 4'hF, 4'h0, 12'h018, 12'h000, 32'h99AABBCC, 32'h0, 1'b1, 1'b0, 4'hF, 10'h006, 32'h99AABBCC};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 12'h000, 32'h0,        32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 12'h010, 12'h000, 32'h0,        32'h0, 1'b1, 1'b0, 4'h0, 10'h004, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 4'h0, 4'h0, 12'h014, 12'h000, 32'h0,        32'h0, 1'b1, 1'b0, 4'h0, 10'h005, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 12'h018, 12'h000, 32'h0,        32'h0, 1'b1, 1'b0, 4'h0, 10'h006, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 12'h000, 32'h0,        32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'h4, 12'h000, 12'h020, 32'h0, 32'h00AB0000, 1'b0, 1'b1, 4'h4, 10'h008, 32'h00AB0000};
        vecs[9]  = '{1'b1, 1'b0, 4'h0, 4'h0, 12'h020, 12'h000, 32'h0,        32'h0, 1'b1, 1'b0, 4'h0, 10'h008, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 12'h000, 32'h0,        32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0};

        drv(0, 0, 4'h0, 4'h0, 12'h0, 12'h0, 32'h0, 32'h0);
        bus1.req_a = 0; bus1.we_a = 4'h0; bus1.addr_a = 12'h0; bus1.wdata_a = 32'h0;
        bus1.req_b = 0; bus1.we_b = 4'h0; bus1.addr_b = 12'h0; bus1.wdata_b = 32'h0;

        // Reset state
        repeat (2) @(negedge HCLK);
        chk("rst_gnt_a", 32'(bus0.gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(bus0.gnt_b), 32'd0);
        chk("rst_enb", 32'(bus0.sram_enb), 32'd0);
        chk("rst_wb", 32'(bus0.sram_wb), 32'd0);
        tick();
        HRESETn = 1'b1;

        // Table: lone-requester writes/reads, port B byte write, read-back
        for (int i = 0; i < 11; i++) begin
            drv(vecs[i].ra, vecs[i].rb, vecs[i].wa, vecs[i].wb, vecs[i].aa, vecs[i].ab, vecs[i].da, vecs[i].db);
            @(negedge HCLK);
            chk($sformatf("v%0d_gnt_a", i), 32'(bus0.gnt_a), 32'(vecs[i].ga));
            chk($sformatf("v%0d_gnt_b", i), 32'(bus0.gnt_b), 32'(vecs[i].gb));
            chk($sformatf("v%0d_enb", i), 32'(bus0.sram_enb), (vecs[i].ga | vecs[i].gb) ? 32'hF : 32'h0);
            chk($sformatf("v%0d_wb", i), 32'(bus0.sram_wb), 32'(vecs[i].ewb));
            if (vecs[i].ga | vecs[i].gb)
                chk($sformatf("v%0d_addr", i), 32'(bus0.sram_addr), 32'(vecs[i].eaddr));
            if (vecs[i].ewb != 4'h0)
                chk($sformatf("v%0d_din", i), bus0.sram_din, vecs[i].edin);
            tick();
        end

        // Continuous contention from IDLE after reset: A x4, B x4, A x4
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drv(1, 1, 4'h0, 4'h0, 12'h010, 12'h014, 32'h0, 32'h0);
            @(negedge HCLK);
            chk($sformatf("cont%0d_gnt_a", i), 32'(bus0.gnt_a), 32'(((i / MB) % 2) == 0));
            chk($sformatf("cont%0d_gnt_b", i), 32'(bus0.gnt_b), 32'(((i / MB) % 2) == 1));
            tick();
        end
        drv(0, 0, 4'h0, 4'h0, 12'h0, 12'h0, 32'h0, 32'h0);
        tick();

        // Owner A at cnt=2 when B arrives: two more A grants, then B
        for (int i = 0; i < 5; i++) begin
            drv(1, i >= 2, 4'h0, 4'h0, 12'h018, 12'h020, 32'h0, 32'h0);
            @(negedge HCLK);
            chk($sformatf("yield%0d_gnt_a", i), 32'(bus0.gnt_a), 32'(i < 4));
            chk($sformatf("yield%0d_gnt_b", i), 32'(bus0.gnt_b), 32'(i == 4));
            tick();
        end
        drv(0, 0, 4'h0, 4'h0, 12'h0, 12'h0, 32'h0, 32'h0);
        tick();

        // Lone requester for 18 cycles (cnt saturates), then B gets the next slot
        for (int i = 0; i < 18; i++) begin
            drv(1, 0, 4'h0, 4'h0, 12'h010, 12'h0, 32'h0, 32'h0);
            @(negedge HCLK);
            chk($sformatf("lone%0d_gnt_a", i), 32'(bus0.gnt_a), 32'd1);
            tick();
        end
        drv(1, 1, 4'h0, 4'h0, 12'h010, 12'h014, 32'h0, 32'h0);
        @(negedge HCLK);
        chk("sat_gnt_b", 32'(bus0.gnt_b), 32'd1);
        chk("sat_gnt_a", 32'(bus0.gnt_a), 32'd0);
        tick();
        drv(0, 0, 4'h0, 4'h0, 12'h0, 12'h0, 32'h0, 32'h0);
        tick();

        // Reset while a port B read is in flight
        drv(0, 1, 4'h0, 4'h0, 12'h0, 12'h014, 32'h0, 32'h0);
        @(negedge HCLK);
        chk("rstf_gnt_b", 32'(bus0.gnt_b), 32'd1);
        #1;
        HRESETn = 1'b0;
        drv(0, 0, 4'h0, 4'h0, 12'h0, 12'h0, 32'h0, 32'h0);
        @(negedge HCLK);
        chk("rstf_rvalid_b0", 32'(bus0.rvalid_b), 32'd0);
        chk("rstf_gnt_b0", 32'(bus0.gnt_b), 32'd0);
        @(negedge HCLK);
        chk("rstf_rvalid_b1", 32'(bus0.rvalid_b), 32'd0);
        tick();
        HRESETn = 1'b1;
        drv(1, 1, 4'h0, 4'h0, 12'h010, 12'h014, 32'h0, 32'h0);
        @(negedge HCLK);
        chk("rstf_tie_gnt_a", 32'(bus0.gnt_a), 32'd1);
        chk("rstf_tie_gnt_b", 32'(bus0.gnt_b), 32'd0);
        chk("rstf_rvalid_b2", 32'(bus0.rvalid_b), 32'd0);
        tick();
        drv(0, 0, 4'h0, 4'h0, 12'h0, 12'h0, 32'h0, 32'h0);

        // MAX_BURST=1 instance: strict alternation A,B,A,B,A,B
        bus1.req_a = 1; bus1.req_b = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            chk($sformatf("alt%0d_gnt_a", i), 32'(bus1.gnt_a), 32'((i % 2) == 0));
            chk($sformatf("alt%0d_gnt_b", i), 32'(bus1.gnt_b), 32'((i % 2) == 1));
            tick();
        end
        bus1.req_a = 0; bus1.req_b = 0;

        repeat (3) tick();
        @(negedge HCLK);
        chk("drain_qa", 32'(qa.size()), 32'd0);
        chk("drain_qb", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
